// File: rtl/edge_stream_packer.sv
// +----------------------------------------------------------------------------+
// | edge_stream_packer: packs 64-bit edges into 8-lane words with pass sideband |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module edge_stream_packer #(
    parameter int                LANES  = 8,
    parameter int                EDGE_W = 64,
    parameter logic [EDGE_W-1:0] PAD    = {EDGE_W{1'b1}}
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [EDGE_W-1:0]         edge_in,
    input  logic                      edge_in_valid,
    input  logic                      edge_in_last,
    output logic                      edge_in_ready,
    input  logic                      flush,
    input  logic [1:0]                control_in,
    output logic [LANES*EDGE_W-1:0]   word_out,
    output logic                      word_out_valid,
    input  logic                      word_out_ready,
    output logic [31:0]               word_out_th,
    output logic                      last_out,
    output logic [1:0]                control_out,
    output logic                      pass_done
);

    localparam int                 c_CNT_W     = $clog2(LANES);
    localparam logic [c_CNT_W-1:0] c_LAST_LANE = c_CNT_W'(LANES - 1);
    localparam logic [0:0]         c_FILL      = 1'b0;
    localparam logic [0:0]         c_CLOSE     = 1'b1;

    logic [0:0]                    r_state;
    logic [c_CNT_W-1:0]            r_lane_cnt;
    logic [LANES-1:0][EDGE_W-1:0]  r_acc;
    logic [LANES*EDGE_W-1:0]       r_word;
    logic                          r_valid;
    logic [31:0]                   r_th;
    logic                          r_last;
    logic [1:0]                    r_ctl;
    logic                          r_pass_done;
    logic [31:0]                   r_word_idx;

    logic [LANES-1:0][EDGE_W-1:0]  w_pack;
    logic                          w_out_free;
    logic                          w_drain;
    logic                          w_accept;
    logic                          w_complete;
    logic                          w_flush;
    logic                          w_close_load;
    logic                          w_load;
    logic [31:0]                   w_idx_base;

    assign w_out_free    = !r_valid || word_out_ready;
    assign w_drain       = r_valid && word_out_ready;
    assign edge_in_ready = rst && (r_state == c_FILL) && w_out_free;
    assign w_accept      = edge_in_valid && edge_in_ready;
    assign w_complete    = w_accept && ((r_lane_cnt == c_LAST_LANE) || edge_in_last);
    assign w_flush       = (r_state == c_FILL) && flush && !edge_in_valid;
    assign w_close_load  = (r_state == c_CLOSE) && w_out_free;
    assign w_load        = w_complete || w_close_load;
    // A word loaded while the previous pass's last word drains starts the new pass at 0
    assign w_idx_base    = (w_drain && r_last) ? 32'd0 : r_word_idx;

    always_comb begin
        w_pack = '0;
        for (int k = 0; k < LANES; k++) begin
            if (c_CNT_W'(k) < r_lane_cnt)
                w_pack[k] = r_acc[k];
            else if ((c_CNT_W'(k) == r_lane_cnt) && (r_state == c_FILL))
                w_pack[k] = edge_in;
            else
                w_pack[k] = PAD;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_FILL;
            r_lane_cnt  <= '0;
            r_acc       <= '0;
            r_word      <= '0;
            r_valid     <= 1'b0;
            r_th        <= '0;
            r_last      <= 1'b0;
            r_ctl       <= '0;
            r_pass_done <= 1'b0;
            r_word_idx  <= '0;
        end else begin
            r_pass_done <= w_drain && r_last;

            if (w_accept && !w_complete) begin
                r_acc[r_lane_cnt] <= edge_in;
                r_lane_cnt        <= r_lane_cnt + 1'b1;
            end

            if (w_load) begin
                r_word     <= w_pack;
                r_valid    <= 1'b1;
                r_th       <= w_idx_base;
                r_word_idx <= w_idx_base + 32'd1;
                r_ctl      <= control_in;
                r_last     <= w_complete ? edge_in_last : 1'b1;
                r_lane_cnt <= '0;
            end else begin
                if (w_drain)
                    r_valid <= 1'b0;
                r_word_idx <= w_idx_base;
            end

            case (r_state)
                c_FILL:  if (w_flush)      r_state <= c_CLOSE;
                c_CLOSE: if (w_close_load) r_state <= c_FILL;
                default:                   r_state <= c_FILL;
            endcase
        end
    end

    assign word_out       = r_word;
    assign word_out_valid = r_valid;
    assign word_out_th    = r_th;
    assign last_out       = r_last;
    assign control_out    = r_ctl;
    assign pass_done      = r_pass_done;

endmodule

`default_nettype wire

// File: tb/tb_edge_stream_packer.sv
// +----------------------------------------------------------------------------+
// | tb_edge_stream_packer: scoreboard bench for edge_stream_packer             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_edge_stream_packer;

    localparam logic [63:0] PAD = 64'hFFFF_FFFF_FFFF_FFFF;

    logic         clk = 1'b0;
    logic         rst;
    logic [63:0]  edge_in;
    logic         edge_in_valid;
    logic         edge_in_last;
    logic         edge_in_ready;
    logic         flush;
    logic [1:0]   control_in;
    logic [511:0] word_out;
    logic         word_out_valid;
    logic         word_out_ready;
    logic [31:0]  word_out_th;
    logic         last_out;
    logic [1:0]   control_out;
    logic         pass_done;

    always #5 clk = ~clk;

    edge_stream_packer dut (
        .clk            (clk),
        .rst            (rst),
        .edge_in        (edge_in),
        .edge_in_valid  (edge_in_valid),
        .edge_in_last   (edge_in_last),
        .edge_in_ready  (edge_in_ready),
        .flush          (flush),
        .control_in     (control_in),
        .word_out       (word_out),
        .word_out_valid (word_out_valid),
        .word_out_ready (word_out_ready),
        .word_out_th    (word_out_th),
        .last_out       (last_out),
        .control_out    (control_out),
        .pass_done      (pass_done)
    );

    typedef struct {
        logic [511:0] w;
        logic [31:0]  th;
        logic         last;
        logic [1:0]   ctl;
    } exp_t;

    exp_t        expq[$];
    logic [63:0] cur[$];
    logic [31:0] m_th = 32'd0;
    int          ncmp = 0;
    int          nfail = 0;
    int          bp_cnt = 0;
    bit          bp_arm = 1'b0;
    bit          ordy_rand = 1'b0;
    bit          pend_lat = 1'b0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
        ncmp++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Reference: a word is the pending edges padded to 8 lanes; th counts words within a pass
    function automatic void push_word(input bit last, input logic [1:0] ctl);
        exp_t x;
        x.w = '0;
        for (int k = 0; k < 8; k++)
            x.w[64*k +: 64] = (k < cur.size()) ? cur[k] : PAD;
        x.th   = m_th;
        x.last = last;
        x.ctl  = ctl;
        expq.push_back(x);
        cur.delete();
        m_th = last ? 32'd0 : m_th + 32'd1;
    endfunction

    task automatic step(input bit v, input logic [63:0] e, input bit l, input bit fl,
                        input logic [1:0] ctl, output bit acc);
        @(negedge clk);
        if (pend_lat) begin
            check("latency_valid", 512'(word_out_valid), 512'(1'b1));
            pend_lat = 1'b0;
        end
        if (bp_cnt > 0) begin
            word_out_ready = 1'b0;
            bp_cnt--;
        end else begin
            word_out_ready = ordy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        edge_in       = e;
        edge_in_valid = v;
        edge_in_last  = l;
        flush         = fl;
        control_in    = ctl;
        #1;
        acc = v && edge_in_ready;
        if (acc) begin
            cur.push_back(e);
            if (cur.size() == 8 || l) begin
                push_word(l, ctl);
                pend_lat = 1'b1;
            end
        end
        if (fl)
            push_word(1'b1, ctl);
    endtask

    task automatic send(input int n, input bit rnd, input int last_at, input int base);
        int  i = 0;
        int  guard = 0;
        bit  acc;
        bit  v;
        bit  l;
        logic [63:0] e;
        while (i < n && guard < n * 40 + 100) begin
            if (bp_arm && word_out_valid) begin
                bp_cnt = 20;
                bp_arm = 1'b0;
            end
            if (rnd) begin
                v = ($urandom_range(0, 3) != 0);
                e = {$urandom, $urandom};
                l = ($urandom_range(0, 15) == 0);
            end else begin
                v = 1'b1;
                e = {32'(base + i + 100), 32'(base + i)};
                l = (i == last_at);
            end
            step(v, e, l, 1'b0, 2'($urandom_range(0, 3)), acc);
            if (acc)
                i++;
            guard++;
        end
        if (i < n) begin
            ncmp++;
            nfail++;
            $display("FAIL send_timeout: accepted %0d required %0d", i, n);
        end
    endtask

    task automatic drain(input logic [1:0] ctl);
        int guard = 0;
        bit acc;
        while ((expq.size() != 0 || word_out_valid) && guard < 400) begin
            step(1'b0, 64'd0, 1'b0, 1'b0, ctl, acc);
            guard++;
        end
        if (expq.size() != 0 || word_out_valid) begin
            ncmp++;
            nfail++;
            $display("FAIL drain_timeout: pending %0d required 0", expq.size());
        end
    endtask

    task automatic flush_pass(input bit timed);
        logic [1:0] ctl;
        bit acc;
        ctl = 2'($urandom_range(0, 3));
        step(1'b0, 64'd0, 1'b0, 1'b1, ctl, acc);
        if (timed) begin
            step(1'b0, 64'd0, 1'b0, 1'b0, ctl, acc);
            check("flush_cycle1_valid", 512'(word_out_valid), 512'(1'b0));
            step(1'b0, 64'd0, 1'b0, 1'b0, ctl, acc);
            check("flush_cycle2_valid_last", 512'({word_out_valid, last_out}), 512'(2'b11));
        end
        drain(ctl);
    endtask

    task automatic check_reset_outputs();
        check("rst_word", word_out, 512'd0);
        check("rst_side", 512'({word_out_valid, word_out_th, last_out, control_out, pass_done, edge_in_ready}),
              512'd0);
    endtask

    // Monitor: pops the scoreboard on every output handshake
    initial begin
        exp_t        x;
        bit          exp_pd = 1'b0;
        bit          hold = 1'b0;
        logic [511:0] pw;
        logic [35:0]  pside;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                exp_pd = 1'b0;
                hold   = 1'b0;
            end else begin
                check("pass_done", 512'(pass_done), 512'(exp_pd));
                if (hold) begin
                    check("hold_word", word_out, pw);
                    check("hold_side", 512'({word_out_valid, word_out_th, last_out, control_out}),
                          512'(pside));
                end
                if (word_out_valid && !word_out_ready)
                    check("bp_in_ready", 512'(edge_in_ready), 512'(1'b0));
                exp_pd = 1'b0;
                if (word_out_valid && word_out_ready) begin
                    if (expq.size() == 0) begin
                        ncmp++;
                        nfail++;
                        $display("FAIL unexpected_word: got th %h required no word", word_out_th);
                    end else begin
                        x = expq.pop_front();
                        check("word", word_out, x.w);
                        check("th", 512'(word_out_th), 512'(x.th));
                        check("last", 512'(last_out), 512'(x.last));
                        check("control", 512'(control_out), 512'(x.ctl));
                        exp_pd = x.last;
                    end
                end
                hold  = word_out_valid && !word_out_ready;
                pw    = word_out;
                pside = {1'b1, word_out_th, last_out, control_out};
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst            = 1'b0;
        edge_in        = '0;
        edge_in_valid  = 1'b0;
        edge_in_last   = 1'b0;
        flush          = 1'b0;
        control_in     = '0;
        word_out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst = 1'b1;

        // Two full words, pass left open, then closed by an empty flush
        send(16, 1'b0, -1, 0);
        drain(2'd0);
        flush_pass(1'b1);

        // Partial last word
        send(3, 1'b0, 2, 1000);
        drain(2'd0);

        // Backpressure on the first word of a 24-edge burst
        bp_arm = 1'b1;
        send(24, 1'b0, -1, 2000);
        drain(2'd0);

        // Reset in the middle of a pass
        send(5, 1'b0, -1, 3000);
        @(negedge clk);
        edge_in_valid = 1'b0;
        flush         = 1'b0;
        rst           = 1'b0;
        cur.delete();
        expq.delete();
        m_th     = 32'd0;
        pend_lat = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst = 1'b1;
        send(8, 1'b0, -1, 4000);
        drain(2'd0);
        flush_pass(1'b0);

        // Word index wrap
        @(negedge clk);
        force dut.r_word_idx = 32'hFFFF_FFFF;
        #1;
        release dut.r_word_idx;
        m_th = 32'hFFFF_FFFF;
        send(16, 1'b0, -1, 5000);
        send(3, 1'b0, 2, 6000);
        drain(2'd0);

        // Randomized traffic with random backpressure and occasional flushes
        ordy_rand = 1'b1;
        for (int r = 0; r < 8; r++) begin
            send(50, 1'b1, -1, 0);
            if ($urandom_range(0, 1) == 1)
                flush_pass(1'b0);
        end
        drain(2'd0);
        ordy_rand = 1'b0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

`default_nettype wire
